mmio_port_bank: RTL and testbench
=================================

// Module: mmio_port_bank
// PURPOSE
//  Parametrised memory-mapped I/O bank on the OTTER IOBUS: N_IN synchronised input ports, N_OUT
//  read-back output registers, per-input change-detect interrupt with mask and W1C status.
//  Sits between Otter_Control and the board pins (switches, LEDs, SSEG); drives MCU INTR.
//  Generalises the fixed switch/LED/SSEG decode into a slot-addressed bank.
// PARAMETERS
//  BASE_AD     32'h11000000  address of slot 0
//  STRIDE      32'h00040000  address spacing between slots
//  N_IN        2             number of input ports (1..32)
//  N_OUT       2             number of output registers (1..32)
//  IN_W        16            width of each input port (1..32)
//  OUT_W       16            width of each output register (1..32)
//  SYNC_STAGES 2             input synchroniser depth (>=2)
// PORTS
//  CLK         in   1             system clock (slck domain)
//  RST         in   1             synchronous active-high reset
//  IOBUS_ADDR  in   32            CPU I/O address
//  IOBUS_OUT   in   32            CPU write data
//  IOBUS_WR    in   1             CPU write strobe, one cycle per store
//  IOBUS_IN    out  32            read data to CPU (combinational on IOBUS_ADDR)
//  IN_PORTS    in   N_IN*IN_W     async board inputs; port i = [i*IN_W +: IN_W]
//  OUT_PORTS   out  N_OUT*OUT_W   output registers; reg j = [j*OUT_W +: OUT_W]
//  INTR        out  1             registered interrupt request to MCU
// BEHAVIOUR
//  Address map (exact 32-bit compare), slot k at BASE_AD + k*STRIDE:
//   k = 0..N_IN-1        IN[k]     RO: synchronised value, zero-extended
//   k = N_IN..+N_OUT-1   OUT[j]    RW: write takes IOBUS_OUT[OUT_W-1:0]; read zero-extended
//   k = N_IN+N_OUT       INT_STAT  RO pending[N_IN-1:0]; write-1-to-clear
//   k = N_IN+N_OUT+1     INT_MASK  RW mask[N_IN-1:0]
//   any other address: read 0, write ignored. Writes to IN slots ignored.
//  Reset (RST high at posedge): OUT regs, sync chains, prev, pending, mask, INTR -> 0;
//   arm counter -> 0. Reset mid-operation aborts everything the same edge; no partial state.
//  Writes: on posedge with IOBUS_WR & decoded slot; OUT_PORTS change at that edge.
//  Input path: IN_PORTS -> SYNC_STAGES flops -> sync; prev <= sync every cycle.
//   Change[i] = (sync[i] != prev[i]) & armed. Latency: pin change before edge t ->
//   readable at t+SYNC_STAGES-1, pending at t+SYNC_STAGES, INTR at t+SYNC_STAGES+1.
//  Arming: after reset, counter counts to SYNC_STAGES+1, then armed=1 and holds;
//   suppresses spurious pending from non-zero pins loaded into zeroed chains.
//  pending[i] next = change[i] | (pending[i] & ~(w1c & IOBUS_OUT[i])); set wins over clear
//   in the same cycle. Bits >= N_IN of W1C/MASK writes ignored, read as 0.
//  INTR <= |(pending & mask) every cycle (one-cycle register after pending/mask update).
//  No back-pressure: every access completes in the cycle presented.
// STRUCTURE
//  otter_mmio_pkg: BASE_AD/STRIDE defaults, slot-index enum (SLOT_IN0, ...), slot_addr() function,
//   legacy constants SWITCHES_AD=32'h11000000, LEDS_AD=32'h11080000, SSEG_AD=32'h110C0000.
//  Sub-module mmio_in_sync: one port's synchroniser chain + prev reg + change flag, generated N_IN times.
//  Top: address decode, OUT regs, pending/mask, arm counter, INTR reg, read mux.
// TESTING (defaults: IN0 @11000000, IN1 @11040000, OUT0 @11080000, OUT1 @110C0000,
//          INT_STAT @11100000, INT_MASK @11140000)
//  1 RST 1 cycle with IN0=16'hA5A5 held -> pending=0, INTR=0 for 10 cycles;
//    read 11000000 after 3 cycles = 32'h0000A5A5.
//  2 WR 11080000 data 32'hDEADBEEF -> OUT0=16'hBEEF next cycle, read = 32'h0000BEEF;
//    WR 11000000 data 1 and WR 11200000 -> no state change, read 11200000 = 0.
//  3 MASK=1; IN0 0000->0001 before edge t -> INT_STAT=1 at t+2, INTR=1 at t+3;
//    WR 11100000 data 1 -> pending 0 that edge, INTR 0 next.
//  4 W1C bit0 issued in the same cycle a new IN0 change is detected -> pending[0] stays 1, INTR stays 1.
//  5 MASK=0, toggle IN1 -> INT_STAT=2, INTR=0; WR MASK=2 -> INTR=1 one cycle after write.
//  6 OUT1=16'h1234, pending=1, MASK=1, then RST -> OUT_PORTS=0, INT_STAT=0, MASK=0, INTR=0 next edge.

Source files
------------

// File: rtl/otter_mmio_pkg.sv
// Shared constants, slot indices and the slot address helper for the OTTER MMIO port bank.
package otter_mmio_pkg;

    // Default placement of the bank on the IOBUS
    localparam logic [31:0] DEF_BASE_AD = 32'h1100_0000;
    localparam logic [31:0] DEF_STRIDE  = 32'h0004_0000;

    // Fixed addresses of the original switch/LED/SSEG decode, kept for existing software
    localparam logic [31:0] SWITCHES_AD = 32'h1100_0000;
    localparam logic [31:0] LEDS_AD     = 32'h1108_0000;
    localparam logic [31:0] SSEG_AD     = 32'h110C_0000;

    // Slot order for the default configuration (two inputs, two outputs)
    typedef enum logic [2:0] {
        SLOT_IN0      = 3'd0,
        SLOT_IN1      = 3'd1,
        SLOT_OUT0     = 3'd2,
        SLOT_OUT1     = 3'd3,
        SLOT_INT_STAT = 3'd4,
        SLOT_INT_MASK = 3'd5
    } slot_e;

    // Address of slot k for a bank placed at base with the given stride
    function automatic logic [31:0] slot_addr(input logic [31:0] base,
                                              input logic [31:0] stride,
                                              input logic [31:0] k);
        return base + (stride * k);
    endfunction

endpackage

// File: rtl/mmio_in_sync.sv
// One input port: synchroniser chain, previous-value register and change flag.
module mmio_in_sync #(
    parameter int IN_W        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [IN_W-1:0] pin_i,
    input  logic            armed_i,
    output logic [IN_W-1:0] sync_o,
    output logic            change_o
);

    logic [IN_W-1:0] chain_q [SYNC_STAGES];
    logic [IN_W-1:0] prev_q;

    // Shift the asynchronous pin value through the synchroniser chain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                chain_q[s] <= '0;
            end
        end else begin
            chain_q[0] <= pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                chain_q[s] <= chain_q[s-1];
            end
        end
    end

    // Remember last cycle's synchronised value for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o   = chain_q[SYNC_STAGES-1];
    // Only report changes once the chain has flushed its reset contents
    assign change_o = armed_i & (chain_q[SYNC_STAGES-1] != prev_q);

endmodule

// File: rtl/mmio_port_bank.sv
// Slot-addressed MMIO bank: synchronised inputs, read-back output registers,
// change-detect interrupt with mask and write-1-to-clear status.
module mmio_port_bank
    import otter_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_AD     = DEF_BASE_AD,
    parameter logic [31:0] STRIDE      = DEF_STRIDE,
    parameter int          N_IN        = 2,
    parameter int          N_OUT       = 2,
    parameter int          IN_W        = 16,
    parameter int          OUT_W       = 16,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [31:0]              IOBUS_ADDR,
    input  logic [31:0]              IOBUS_OUT,
    input  logic                     IOBUS_WR,
    output logic [31:0]              IOBUS_IN,
    input  logic [N_IN*IN_W-1:0]     IN_PORTS,
    output logic [N_OUT*OUT_W-1:0]   OUT_PORTS,
    output logic                     INTR
);

    localparam int SLOT_STAT = N_IN + N_OUT;
    localparam int SLOT_MASK = N_IN + N_OUT + 1;
    localparam int ARM_W     = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

    localparam logic [31:0] STAT_AD = slot_addr(BASE_AD, STRIDE, 32'(SLOT_STAT));
    localparam logic [31:0] MASK_AD = slot_addr(BASE_AD, STRIDE, 32'(SLOT_MASK));

    logic [IN_W-1:0]  in_sync_s [N_IN];
    logic [N_IN-1:0]  change_s;
    logic             armed_s;

    logic [OUT_W-1:0] out_q [N_OUT];
    logic [OUT_W-1:0] out_d [N_OUT];
    logic [N_IN-1:0]  pending_q, pending_d;
    logic [N_IN-1:0]  mask_q, mask_d;
    logic [N_IN-1:0]  w1c_s;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             intr_q, intr_d;

    logic [N_OUT-1:0] wr_out_s;
    logic             wr_stat_s;
    logic             wr_mask_s;
    logic [31:0]      rd_s;

    // Per-port synchroniser and change detector
    for (genvar g = 0; g < N_IN; g++) begin : g_in
        mmio_in_sync #(
            .IN_W        (IN_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_in_sync (
            .clk_i    (CLK),
            .rst_i    (RST),
            .pin_i    (IN_PORTS[g*IN_W +: IN_W]),
            .armed_i  (armed_s),
            .sync_o   (in_sync_s[g]),
            .change_o (change_s[g])
        );
    end

    // Pack the output registers onto the board pins
    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        assign OUT_PORTS[j*OUT_W +: OUT_W] = out_q[j];
    end

    assign armed_s = (arm_cnt_q == ARM_MAX);

    // Decode write strobes for every writable slot (IN slots have no write path)
    always_comb begin
        wr_out_s = '0;
        for (int j = 0; j < N_OUT; j++) begin
            wr_out_s[j] = IOBUS_WR & (IOBUS_ADDR == slot_addr(BASE_AD, STRIDE, 32'(N_IN + j)));
        end
        wr_stat_s = IOBUS_WR & (IOBUS_ADDR == STAT_AD);
        wr_mask_s = IOBUS_WR & (IOBUS_ADDR == MASK_AD);
    end

    // Read mux: at most one slot matches, unmatched addresses read zero
    always_comb begin
        rd_s = 32'h0000_0000;
        for (int i = 0; i < N_IN; i++) begin
            rd_s = rd_s | ({32{IOBUS_ADDR == slot_addr(BASE_AD, STRIDE, 32'(i))}}
                           & 32'(in_sync_s[i]));
        end
        for (int j = 0; j < N_OUT; j++) begin
            rd_s = rd_s | ({32{IOBUS_ADDR == slot_addr(BASE_AD, STRIDE, 32'(N_IN + j))}}
                           & 32'(out_q[j]));
        end
        rd_s = rd_s | ({32{IOBUS_ADDR == STAT_AD}} & 32'(pending_q));
        rd_s = rd_s | ({32{IOBUS_ADDR == MASK_AD}} & 32'(mask_q));
    end

    assign IOBUS_IN = rd_s;

    // Next-state for output registers, interrupt status/mask, arm counter and INTR
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            out_d[j] = wr_out_s[j] ? IOBUS_OUT[OUT_W-1:0] : out_q[j];
        end
        w1c_s     = wr_stat_s ? IOBUS_OUT[N_IN-1:0] : '0;
        // A change detected this cycle wins over a simultaneous clear
        pending_d = change_s | (pending_q & ~w1c_s);
        mask_d    = wr_mask_s ? IOBUS_OUT[N_IN-1:0] : mask_q;
        arm_cnt_d = armed_s ? arm_cnt_q : (arm_cnt_q + ARM_W'(1));
        intr_d    = |(pending_q & mask_q);
    end

    // State registers; reset clears everything on the same edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int j = 0; j < N_OUT; j++) begin
                out_q[j] <= '0;
            end
            pending_q <= '0;
            mask_q    <= '0;
            arm_cnt_q <= '0;
            intr_q    <= 1'b0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                out_q[j] <= out_d[j];
            end
            pending_q <= pending_d;
            mask_q    <= mask_d;
            arm_cnt_q <= arm_cnt_d;
            intr_q    <= intr_d;
        end
    end

    assign INTR = intr_q;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Randomised scoreboard bench for mmio_port_bank (default parameters).
module tb_mmio_port_bank;

    localparam int S = 2;
    localparam logic [31:0] A_IN0  = 32'h1100_0000;
    localparam logic [31:0] A_IN1  = 32'h1104_0000;
    localparam logic [31:0] A_OUT0 = 32'h1108_0000;
    localparam logic [31:0] A_OUT1 = 32'h110C_0000;
    localparam logic [31:0] A_STAT = 32'h1110_0000;
    localparam logic [31:0] A_MASK = 32'h1114_0000;
    localparam logic [31:0] A_BAD  = 32'h1120_0000;
    localparam logic [31:0] A_BAD2 = 32'h1100_0004;

    logic        CLK;
    logic        RST;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic [31:0] IN_PORTS;
    logic [31:0] OUT_PORTS;
    logic        INTR;

    mmio_port_bank dut (
        .CLK        (CLK),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .IN_PORTS   (IN_PORTS),
        .OUT_PORTS  (OUT_PORTS),
        .INTR       (INTR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rd;
        logic [31:0] outs;
        logic        intr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_pop    = 0;

    // Reference model: pins sampled at each edge since the last reset
    int          mk;
    logic [31:0] hist[$];
    logic [15:0] m_out [2];
    logic [1:0]  m_pend;
    logic [1:0]  m_mask;
    logic        m_intr;
    bit          m_valid = 1'b0;
    logic [31:0] pins;

    logic [31:0] addrs [8] = '{A_IN0, A_IN1, A_OUT0, A_OUT1, A_STAT, A_MASK, A_BAD, A_BAD2};

    // Synchronised value of a port after edge kk: the pin sampled S-1 edges earlier
    function automatic logic [15:0] m_sync(input int kk, input int port);
        int idx;
        idx = kk - S + 1;
        if (idx < 1) return 16'h0000;
        return hist[idx][port*16 +: 16];
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        case (a)
            A_IN0:   return {16'h0000, m_sync(mk, 0)};
            A_IN1:   return {16'h0000, m_sync(mk, 1)};
            A_OUT0:  return {16'h0000, m_out[0]};
            A_OUT1:  return {16'h0000, m_out[1]};
            A_STAT:  return {30'h0, m_pend};
            A_MASK:  return {30'h0, m_mask};
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic void model_step(input logic rst, input logic wr, input logic [31:0] a,
                                       input logic [31:0] d, input logic [31:0] p);
        logic [1:0] chg;
        logic [1:0] w1c;
        logic       nintr;
        if (rst) begin
            mk = 0;
            hist.delete();
            hist.push_back(32'h0);
            m_out[0] = 16'h0; m_out[1] = 16'h0;
            m_pend = 2'b00; m_mask = 2'b00; m_intr = 1'b0;
            m_valid = 1'b1;
        end else begin
            mk++;
            hist.push_back(p);
            nintr = |(m_pend & m_mask);
            chg = 2'b00;
            for (int q = 0; q < 2; q++) begin
                if (mk - 1 >= S + 1 && m_sync(mk - 1, q) != m_sync(mk - 2, q)) chg[q] = 1'b1;
            end
            w1c = (wr && a == A_STAT) ? d[1:0] : 2'b00;
            m_pend = chg | (m_pend & ~w1c);
            if (wr && a == A_MASK) m_mask = d[1:0];
            if (wr && a == A_OUT0) m_out[0] = d[15:0];
            if (wr && a == A_OUT1) m_out[1] = d[15:0];
            m_intr = nintr;
        end
    endfunction

    function automatic void check(input string nm, input logic [31:0] a,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s addr=%h actual=%h expected=%h", nm, a, act, exp);
        end
    endfunction

    // One bus cycle: drive, queue the expectation for this cycle, then advance the model
    task automatic cyc(input logic rst, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] p);
        exp_t e;
        RST = rst; IOBUS_WR = wr; IOBUS_ADDR = a; IOBUS_OUT = d; IN_PORTS = p;
        if (m_valid) begin
            e.addr = a;
            e.rd   = exp_read(a);
            e.outs = {m_out[1], m_out[0]};
            e.intr = m_intr;
            sb.push_back(e);
            n_push++;
        end
        @(posedge CLK);
        model_step(rst, wr, a, d, p);
        #1;
    endtask

    task automatic idle(input int n, input logic [31:0] a);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, a, 32'h0, pins);
    endtask

    // Monitor: compare every queued expectation mid-cycle
    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_pop++;
            check("read",      e.addr, IOBUS_IN,  e.rd);
            check("out_ports", e.addr, OUT_PORTS, e.outs);
            check("intr",      e.addr, {31'h0, INTR}, {31'h0, e.intr});
        end
    end

    initial begin
        RST = 1'b0; IOBUS_WR = 1'b0; IOBUS_ADDR = 32'h0; IOBUS_OUT = 32'h0; IN_PORTS = 32'h0;
        @(posedge CLK); #1;

        // Reset with a non-zero pin held: no spurious pending
        pins = 32'h0000_A5A5;
        cyc(1'b1, 1'b0, A_IN0, 32'h0, pins);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, (i % 2 == 0) ? A_IN0 : A_STAT, 32'h0, pins);

        // Output write, ignored writes to IN slot and unmapped address
        cyc(1'b0, 1'b1, A_OUT0, 32'hDEAD_BEEF, pins);
        idle(1, A_OUT0);
        cyc(1'b0, 1'b1, A_IN0, 32'h0000_0001, pins);
        cyc(1'b0, 1'b1, A_BAD, 32'hFFFF_FFFF, pins);
        idle(1, A_BAD);
        idle(1, A_IN0);

        // Masked change on IN0, then clear
        cyc(1'b0, 1'b1, A_MASK, 32'h0000_0001, pins);
        pins = 32'h0000_0000;
        idle(4, A_STAT);
        cyc(1'b0, 1'b1, A_STAT, 32'hFFFF_FFFF, pins);
        idle(2, A_STAT);
        pins = 32'h0000_0001;
        idle(4, A_STAT);
        cyc(1'b0, 1'b1, A_STAT, 32'h0000_0001, pins);
        idle(2, A_STAT);

        // Clear issued on the very edge a new change is detected
        pins = 32'h0000_0003;
        idle(4, A_STAT);
        pins = 32'h0000_0007;
        idle(2, A_STAT);
        cyc(1'b0, 1'b1, A_STAT, 32'h0000_0001, pins);
        idle(3, A_STAT);

        // Unmasked IN1 change, then enable its mask
        cyc(1'b0, 1'b1, A_STAT, 32'h0000_0003, pins);
        cyc(1'b0, 1'b1, A_MASK, 32'h0000_0000, pins);
        pins = pins ^ 32'h0001_0000;
        idle(4, A_STAT);
        cyc(1'b0, 1'b1, A_MASK, 32'h0000_0002, pins);
        idle(3, A_MASK);

        // Reset mid-operation
        cyc(1'b0, 1'b1, A_OUT1, 32'h0000_1234, pins);
        cyc(1'b0, 1'b1, A_MASK, 32'h0000_0001, pins);
        pins = pins ^ 32'h0000_0001;
        idle(4, A_STAT);
        cyc(1'b1, 1'b0, A_OUT1, 32'h0, pins);
        idle(2, A_STAT);
        idle(1, A_MASK);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            logic r;
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) pins = pins ^ (32'h1 << $urandom_range(0, 31));
            cyc(r, 1'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)], $urandom(), pins);
        end

        @(posedge CLK); #1;
        check("sb_drained", 32'h0, 32'(sb.size()), 32'h0);
        check("sb_count",   32'h0, 32'(n_pop), 32'(n_push));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
